// File: rtl/onchip_mem_dp_pipe_pkg.sv
// Shared constants and the byte-lane merge helper for the dual-port on-chip RAM.
package onchip_mem_pkg;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    // Widest word the merge helper handles; callers zero-extend in and truncate out.
    localparam int MAX_DATA_W = 2048;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef logic [MAX_DATA_W-1:0] word_t;
    typedef logic [MAX_BE_W-1:0]   be_t;

    // Each byte lane comes from new_w where be is set, otherwise from old_w.
    function automatic word_t merge_be(input word_t old_w, input word_t new_w, input be_t be);
        word_t mask;
        mask = '0;
        for (int i = 0; i < MAX_BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

endpackage

// File: rtl/onchip_mem_dp_pipe_if.sv
// One Avalon-MM slave port of the dual-port RAM (address/control/data plus read-valid).
interface onchip_mem_dp_pipe_if #(
    parameter int DATA_W = 1024,
    parameter int DEPTH  = 64
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_mem_dp_pipe_rd_pipe.sv
// Per-port read pipeline: collision bypass at stage 0, optional output register at stage 1.
module onchip_mem_rd_pipe
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W       = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic                rd_acc_i,
    input  logic [DATA_W-1:0]   rd_word_i,
    input  logic                coll_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o
);

    logic [DATA_W-1:0] data_p0_d;
    logic [DATA_W-1:0] data_p0_q;
    logic              vld_p0_q;

    // Bypass: when the other port writes this address now, the read sees its enabled lanes.
    always_comb begin
        data_p0_d = rd_word_i;
        if (coll_i) begin
            data_p0_d = DATA_W'(merge_be(word_t'(rd_word_i), word_t'(wr_data_i), be_t'(wr_be_i)));
        end
    end

    // Stage 0: capture read word on accept; data holds between reads, everything freezes when disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0_q  <= 1'b0;
            data_p0_q <= '0;
        end else if (en_i) begin
            vld_p0_q <= rd_acc_i;
            if (rd_acc_i) begin
                data_p0_q <= data_p0_d;
            end
        end
    end

    generate
        if (READ_LATENCY >= LAT_MAX) begin : g_lat2
            logic [DATA_W-1:0] data_p1_q;
            logic              vld_p1_q;

            // Stage 1: extra output register; loads only when stage 0 holds a valid word.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_p1_q  <= 1'b0;
                    data_p1_q <= '0;
                end else if (en_i) begin
                    vld_p1_q <= vld_p0_q;
                    if (vld_p0_q) begin
                        data_p1_q <= data_p0_q;
                    end
                end
            end

            assign rdata_o  = data_p1_q;
            assign rvalid_o = vld_p1_q;
        end else begin : g_lat1
            assign rdata_o  = data_p0_q;
            assign rvalid_o = vld_p0_q;
        end
    endgenerate

endmodule

// File: rtl/onchip_mem_dp_pipe.sv
// True dual-port byte-enabled RAM with per-port read-valid pipelines and mixed-port forwarding.
module onchip_mem_dp_pipe
    import onchip_mem_pkg::*;
#(
    parameter int    DATA_W       = 1024,
    parameter int    DEPTH        = 64,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_mem_dp_pipe.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic                clken,
    onchip_mem_dp_pipe_if.slave s1,
    onchip_mem_dp_pipe_if.slave s2
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              en;
    logic              wr_a, rd_a, wr_b, rd_b;
    logic              same_addr;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_old, b_old;
    logic [DATA_W-1:0] a_base;
    logic [DATA_W-1:0] a_word_d, b_word_d;

    assign en        = clken & ~reset_req;
    assign a_addr    = s1.address;
    assign b_addr    = s2.address;
    assign same_addr = (a_addr == b_addr);

    // A write beats a read on the same port, so a port never reads and writes together.
    assign wr_a = en & s1.chipselect & s1.write;
    assign rd_a = en & s1.chipselect & s1.read & ~s1.write;
    assign wr_b = en & s2.chipselect & s2.write;
    assign rd_b = en & s2.chipselect & s2.read & ~s2.write;

    assign a_old = mem_q[a_addr];
    assign b_old = mem_q[b_addr];

    // Write words: B merges over the old word; on a shared address A merges over B's result so A wins its lanes.
    always_comb begin
        b_word_d = DATA_W'(merge_be(word_t'(b_old), word_t'(s2.writedata), be_t'(s2.byteenable)));
        a_base   = (wr_b && same_addr) ? b_word_d : a_old;
        a_word_d = DATA_W'(merge_be(word_t'(a_base), word_t'(s1.writedata), be_t'(s1.byteenable)));
    end

    // Array update; not reset, so a write coinciding with reset still lands.
    always_ff @(posedge clk) begin
        if (wr_b) begin
            mem_q[b_addr] <= b_word_d;
        end
        if (wr_a) begin
            mem_q[a_addr] <= a_word_d;
        end
    end

    onchip_mem_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_a (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en),
        .rd_acc_i  (rd_a),
        .rd_word_i (a_old),
        .coll_i    (wr_b && same_addr),
        .wr_data_i (s2.writedata),
        .wr_be_i   (s2.byteenable),
        .rdata_o   (s1.readdata),
        .rvalid_o  (s1.readdatavalid)
    );

    onchip_mem_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_b (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en),
        .rd_acc_i  (rd_b),
        .rd_word_i (b_old),
        .coll_i    (wr_a && same_addr),
        .wr_data_i (s1.writedata),
        .wr_be_i   (s1.byteenable),
        .rdata_o   (s2.readdata),
        .rvalid_o  (s2.readdatavalid)
    );

endmodule

// File: tb/tb_onchip_mem_dp_pipe.sv
// Bench for onchip_mem_dp_pipe: two DUTs (read latency 1 and 2) on identical stimulus,
// checked every cycle against a transaction-level memory model plus directed literals.
module tb_onchip_mem_dp_pipe;

    localparam int DW = 1024;
    localparam int DP = 64;
    localparam int BW = DW / 8;
    localparam int AW = $clog2(DP);

    typedef logic [DW-1:0] word_t;
    typedef logic [BW-1:0] be_t;
    typedef struct { int k; word_t data; } rd_ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_req = 1'b0;
    logic clken = 1'b1;

    always #5 clk = ~clk;

    onchip_mem_dp_pipe_if #(.DATA_W(DW), .DEPTH(DP)) s1_l1 ();
    onchip_mem_dp_pipe_if #(.DATA_W(DW), .DEPTH(DP)) s2_l1 ();
    onchip_mem_dp_pipe_if #(.DATA_W(DW), .DEPTH(DP)) s1_l2 ();
    onchip_mem_dp_pipe_if #(.DATA_W(DW), .DEPTH(DP)) s2_l2 ();

    assign s1_l2.address    = s1_l1.address;
    assign s1_l2.chipselect = s1_l1.chipselect;
    assign s1_l2.read       = s1_l1.read;
    assign s1_l2.write      = s1_l1.write;
    assign s1_l2.byteenable = s1_l1.byteenable;
    assign s1_l2.writedata  = s1_l1.writedata;
    assign s2_l2.address    = s2_l1.address;
    assign s2_l2.chipselect = s2_l1.chipselect;
    assign s2_l2.read       = s2_l1.read;
    assign s2_l2.write      = s2_l1.write;
    assign s2_l2.byteenable = s2_l1.byteenable;
    assign s2_l2.writedata  = s2_l1.writedata;

    onchip_mem_dp_pipe #(.DATA_W(DW), .DEPTH(DP), .READ_LATENCY(1), .INIT_FILE("")) dut_l1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .s1(s1_l1), .s2(s2_l1)
    );
    onchip_mem_dp_pipe #(.DATA_W(DW), .DEPTH(DP), .READ_LATENCY(2), .INIT_FILE("")) dut_l2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .s1(s1_l2), .s2(s2_l2)
    );

    // [d][p]: d=0 latency 1, d=1 latency 2; p=0 port A, p=1 port B
    logic  act_v [2][2];
    word_t act_d [2][2];
    assign act_v[0][0] = s1_l1.readdatavalid;
    assign act_v[0][1] = s2_l1.readdatavalid;
    assign act_v[1][0] = s1_l2.readdatavalid;
    assign act_v[1][1] = s2_l2.readdatavalid;
    assign act_d[0][0] = s1_l1.readdata;
    assign act_d[0][1] = s2_l1.readdata;
    assign act_d[1][0] = s1_l2.readdata;
    assign act_d[1][1] = s2_l2.readdata;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    task automatic check_word(input string nm, input word_t act, input word_t exp);
        int ln;
        n_chk++;
        if (act !== exp) begin
            ln = 0;
            for (int i = BW - 1; i >= 0; i--) begin
                if (act[8*i +: 8] !== exp[8*i +: 8]) ln = i;
            end
            n_fail++;
            $display("FAIL %s: lane %0d got %02h required %02h (low 64b got %016h required %016h)",
                     nm, ln, act[8*ln +: 8], exp[8*ln +: 8], act[63:0], exp[63:0]);
        end
    endtask

    // ---------------- behavioural model ----------------
    word_t  mem_m [DP];
    rd_ev_t pend [2][2][$];
    word_t  last_d [2][2];
    int     last_k [2][2];
    int     ecnt = 0;
    bit     chk_on = 1'b0;

    always @(posedge clk) begin : model
        bit    en_m, wa, wb, ra, rb;
        word_t rda, rdb;
        en_m = clken && !reset_req;
        wa = en_m && s1_l1.chipselect && s1_l1.write;
        ra = en_m && s1_l1.chipselect && s1_l1.read && !s1_l1.write;
        wb = en_m && s2_l1.chipselect && s2_l1.write;
        rb = en_m && s2_l1.chipselect && s2_l1.read && !s2_l1.write;
        // Port B lanes first, then port A lanes on top (A wins shared lanes).
        for (int i = 0; i < BW; i++) begin
            if (wb && s2_l1.byteenable[i]) mem_m[s2_l1.address][8*i +: 8] = s2_l1.writedata[8*i +: 8];
        end
        for (int i = 0; i < BW; i++) begin
            if (wa && s1_l1.byteenable[i]) mem_m[s1_l1.address][8*i +: 8] = s1_l1.writedata[8*i +: 8];
        end
        // A reading port never writes, so post-write contents are exactly the "new data" view.
        rda = mem_m[s1_l1.address];
        rdb = mem_m[s2_l1.address];
        if (reset) begin
            chk_on = 1'b1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    pend[d][p].delete();
                    last_d[d][p] = '0;
                    last_k[d][p] = -100;
                end
            end
        end else if (en_m) begin
            ecnt++;
            for (int d = 0; d < 2; d++) begin
                if (ra) pend[d][0].push_back('{k: ecnt, data: rda});
                if (rb) pend[d][1].push_back('{k: ecnt, data: rdb});
            end
        end
    end

    // A read accepted on enabled edge k is visible after enabled edge k+latency-1.
    always @(posedge clk) begin : compare
        #1;
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    while (pend[d][p].size() > 0 && pend[d][p][0].k + d <= ecnt) begin
                        last_d[d][p] = pend[d][p][0].data;
                        last_k[d][p] = pend[d][p][0].k;
                        void'(pend[d][p].pop_front());
                    end
                    check_bit($sformatf("model lat%0d port%0d valid", d + 1, p),
                              act_v[d][p], (last_k[d][p] + d == ecnt));
                    check_word($sformatf("model lat%0d port%0d data", d + 1, p),
                               act_d[d][p], last_d[d][p]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_port(input int p, input bit cs, input bit rd, input bit wr,
                            input int addr, input be_t be, input word_t d);
        if (p == 0) begin
            s1_l1.chipselect = cs; s1_l1.read = rd; s1_l1.write = wr;
            s1_l1.address = AW'(addr); s1_l1.byteenable = be; s1_l1.writedata = d;
        end else begin
            s2_l1.chipselect = cs; s2_l1.read = rd; s2_l1.write = wr;
            s2_l1.address = AW'(addr); s2_l1.byteenable = be; s2_l1.writedata = d;
        end
    endtask

    task automatic wr(input int p, input int addr, input be_t be, input word_t d);
        set_port(p, 1'b1, 1'b0, 1'b1, addr, be, d);
    endtask

    task automatic rd(input int p, input int addr);
        set_port(p, 1'b1, 1'b1, 1'b0, addr, '0, '0);
    endtask

    task automatic idle_all();
        set_port(0, 1'b0, 1'b0, 1'b0, 0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, 0, '0, '0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    be_t   be_lo;
    word_t split_w;

    initial begin
        be_lo = {{(BW/2){1'b0}}, {(BW/2){1'b1}}};
        idle_all();
        tick(); tick();
        reset = 1'b0;
        check_bit("reset lat1 A valid", s1_l1.readdatavalid, 1'b0);
        check_word("reset lat2 B data", s2_l2.readdata, '0);

        // Basic write then read, both latencies
        wr(0, 5, '1, {BW{8'hAA}}); tick();
        idle_all(); rd(1, 5); tick();
        check_bit("t1 lat1 valid", s2_l1.readdatavalid, 1'b1);
        check_word("t1 lat1 data", s2_l1.readdata, {BW{8'hAA}});
        check_bit("t1 lat2 not yet", s2_l2.readdatavalid, 1'b0);
        idle_all(); tick();
        check_bit("t1 lat1 single pulse", s2_l1.readdatavalid, 1'b0);
        check_bit("t1 lat2 valid", s2_l2.readdatavalid, 1'b1);
        check_word("t1 lat2 data", s2_l2.readdata, {BW{8'hAA}});
        tick();
        check_bit("t1 lat2 single pulse", s2_l2.readdatavalid, 1'b0);

        // Preload word=address, then stream with a 3-cycle clken hold
        for (int i = 0; i < DP; i++) begin
            wr(0, i, '1, word_t'(i)); tick();
        end
        idle_all();
        for (int i = 0; i < DP; i++) begin
            rd(1, i);
            if (i == 30) begin
                clken = 1'b0;
                repeat (3) begin
                    tick();
                    check_bit("t2 frozen valid", s2_l1.readdatavalid, 1'b1);
                    check_word("t2 frozen data", s2_l1.readdata, word_t'(29));
                end
                clken = 1'b1;
            end
            tick();
            check_bit("t2 stream valid", s2_l1.readdatavalid, 1'b1);
            check_word("t2 stream data", s2_l1.readdata, word_t'(i));
        end
        idle_all(); tick(); tick();

        // Mixed-port collision with lower-half byteenable
        split_w = {{(BW/2){8'h11}}, {(BW/2){8'h22}}};
        wr(0, 9, '1, {BW{8'h11}}); tick();
        wr(0, 9, be_lo, {BW{8'h22}}); rd(1, 9); tick();
        check_word("t3 bypass lat1", s2_l1.readdata, split_w);
        idle_all(); tick();
        check_word("t3 bypass lat2", s2_l2.readdata, split_w);

        // Write-write collision
        wr(0, 3, be_lo, {BW{8'h33}}); wr(1, 3, '1, {BW{8'h44}}); tick();
        idle_all(); rd(0, 3); tick();
        check_word("t4 write-write", s1_l1.readdata, {{(BW/2){8'h44}}, {(BW/2){8'h33}}});
        idle_all(); tick();

        // Reset while a read is in flight
        rd(1, 5); tick();
        idle_all(); reset = 1'b1; tick();
        check_bit("t5 lat2 valid killed", s2_l2.readdatavalid, 1'b0);
        check_word("t5 lat2 data zero", s2_l2.readdata, '0);
        check_bit("t5 lat1 valid cleared", s2_l1.readdatavalid, 1'b0);
        reset = 1'b0; tick();
        check_bit("t5 lat2 still no valid", s2_l2.readdatavalid, 1'b0);
        check_word("t5 lat2 data still zero", s2_l2.readdata, '0);
        rd(1, 5); tick(); idle_all(); tick();
        check_bit("t5 reread valid", s2_l2.readdatavalid, 1'b1);
        check_word("t5 reread data", s2_l2.readdata, word_t'(5));

        // reset_req gating, same-port read+write, zero byteenable, no chipselect
        reset_req = 1'b1; wr(0, 7, '1, {BW{8'h77}}); tick();
        reset_req = 1'b0; idle_all(); rd(0, 7); tick();
        check_word("t6 gated write dropped", s1_l1.readdata, word_t'(7));
        set_port(0, 1'b1, 1'b1, 1'b1, 12, '1, {BW{8'hCC}}); tick();
        check_bit("t6 rw no valid", s1_l1.readdatavalid, 1'b0);
        check_word("t6 rw data holds", s1_l1.readdata, word_t'(7));
        idle_all(); tick();
        check_bit("t6 rw no valid lat2", s1_l2.readdatavalid, 1'b0);
        wr(0, 12, '0, {BW{8'hDD}}); tick();
        idle_all(); rd(0, 12); tick();
        check_word("t6 rw committed, zero-be no-op", s1_l1.readdata, {BW{8'hCC}});
        idle_all(); rd(1, 12); tick();
        check_bit("t6 B read valid", s2_l1.readdatavalid, 1'b1);
        set_port(1, 1'b0, 1'b1, 1'b0, 12, '0, '0); tick();
        check_bit("t6 no chipselect", s2_l1.readdatavalid, 1'b0);

        idle_all();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_mem_dp_pipe.md
Name: onchip_mem_dp_pipe

Overview:
- Parametrised true dual-port on-chip RAM with two Avalon-MM slave ports, s1 (port A) and s2 (port B). Both ports share one clock.
- Successor to the fixed 1024x64 single-port image memory. Adds configurable width, depth and read latency, a per-port readdatavalid pipeline, and a defined mixed-port collision policy with byte-merged forwarding.
- Sits between the Nios/DMA fabric and the Sobel pixel engine. Typical use: CPU or DMA loads a frame line through s1 while the filter streams wide words through s2.

Parameters:
- DATA_W, 1024, word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values are 1 and 2. A value of 2 adds an output register.
- INIT_FILE, "onchip_mem_dp_pipe.hex", array initialisation image; "" means the array is uninitialised.

Ports:
- clk  in  1  single clock for both ports
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  when high, forces the internal clock enable low (same role as clocken0 gating)
- clken  in  1  global clock enable; when low the whole block holds state
- a_address  in  ADDR_W  port A word address
- a_chipselect  in  1  port A select
- a_read  in  1  port A read request
- a_write  in  1  port A write request
- a_byteenable  in  DATA_W/8  port A byte lanes
- a_writedata  in  DATA_W  port A write data
- a_readdata  out  DATA_W  port A read data
- a_readdatavalid  out  1  port A read data valid, one-cycle pulse per read
- b_* : identical set for port B (b_address ... b_readdatavalid)

Behaviour:
- en = clken & ~reset_req. When en is low, nothing happens:
  - no array update, no read accept;
  - pipeline registers and outputs hold their values;
  - readdatavalid holds its value, so a pending pulse is stretched. Masters must only sample readdatavalid with clken high.
- Accepts:
  - A write is accepted when en & chipselect & write.
  - A read is accepted when en & chipselect & read & ~write. A write wins: with read and write both high, the read is dropped and no valid is produced.
- Byte-enabled write: lane i (bits 8i+7:8i) is updated only when byteenable[i]=1. A write with byteenable all zero is a no-op.
- Read latency:
  - A read accepted in cycle N gives readdata and readdatavalid=1 in cycle N+READ_LATENCY.
  - Back-to-back reads are supported, one per cycle per port, with no waitrequest.
  - readdata holds its last value when readdatavalid=0.
- Same-port read-during-write cannot occur, because write wins.
- Mixed-port collision (read on one port, write on the other, same address, same cycle): the read returns NEW data. Each lane is taken from the write when that lane's byteenable is set, otherwise from the old array contents. This is implemented with a registered bypass mux, not a memory-inferred mode.
- Write-write collision (both ports write the same address in the same cycle): port A wins on each lane where a_byteenable is set. Lanes where only b_byteenable is set take port B's data.
- Reset:
  - On reset=1 at a clk edge: readdatavalid and all pipeline valid bits go to 0, and readdata goes to 0. This takes effect regardless of en.
  - The array contents are NOT reset; they retain their data or INIT_FILE contents.
  - A read in flight when reset is asserted is discarded; its valid is never produced.
  - A write in the same cycle as reset is still committed to the array.
- Address wrap: the address is exactly ADDR_W bits, so there is no out-of-range case.

Decomposition:
- Package onchip_mem_pkg:
  - constants LAT_MIN=1 and LAT_MAX=2;
  - a byte-merge function merge_be(old, new, be) used by both the bypass path and the write-write resolution.
- Sub-module onchip_mem_rd_pipe, instantiated once per port:
  - carries the valid and data shift pipeline of depth READ_LATENCY;
  - takes the en and reset inputs;
  - includes the collision bypass mux at stage 0.

Test Plan:
1. Reset, then an A write to addr 5 (0xAA.. all lanes), then a B read of addr 5 → b_readdatavalid pulses exactly 1 cycle after accept (READ_LATENCY=1; 2 cycles when 2) and b_readdata=0xAA...
2. Streaming: B reads addrs 0..63 on consecutive cycles, with the array preloaded to word=address → 64 consecutive valid pulses with data 0..63 in order. Also, clken held low for 3 cycles mid-stream → outputs frozen and no data lost.
3. Mixed collision: addr 9 holds 0x11 in every byte; in one cycle A writes 0x22.. with a_byteenable=lanes 0–63 only while B reads addr 9 → b_readdata lanes 0–63=0x22 and lanes 64–127=0x11.
4. Write-write collision: both ports write addr 3 with A be=lower half (0x33) and B be=all lanes (0x44) → a subsequent read gives the lower half 0x33 and the upper half 0x44.
5. Reset mid-read: with READ_LATENCY=2, a read is accepted and reset is asserted on the next cycle → no readdatavalid is ever produced and readdata=0; array contents are unchanged when re-read.
6. reset_req=1 while A writes addr 7 → addr 7 is unchanged on readback after reset_req drops. A concurrent read + write on port A → write committed and no valid produced.
